// File: rtl/exe_vector_unit_if.sv
// Bundle between the ID/EXE pipeline register and the execute stage.
// The master side is the pipeline register; the slave side is the execute unit.
interface exe_vector_unit_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic [WIDTH-1:0] op01_in, op11_in, op21_in, op31_in;
    logic [WIDTH-1:0] op02_in, op12_in, op22_in, op32_in;
    logic [WIDTH-1:0] op1, op2;
    logic [3:0]       rd_in;
    logic [3:0]       aluControl_in;
    logic             regWrite_in, memWrite_in, branch_in, resultSrc_in, updateCount_in;
    logic             stop;
    logic [WIDTH-1:0] res0, res1, res2, res3;
    logic [WIDTH-1:0] sres;
    logic             zero;
    logic [3:0]       rd_out;
    logic             regWrite_out, memWrite_out, branch_out, resultSrc_out, updateCount_out;
    logic             out_valid;

    modport master (
        output in_valid, op01_in, op11_in, op21_in, op31_in,
               op02_in, op12_in, op22_in, op32_in, op1, op2, rd_in, aluControl_in,
               regWrite_in, memWrite_in, branch_in, resultSrc_in, updateCount_in,
        input  stop, res0, res1, res2, res3, sres, zero, rd_out,
               regWrite_out, memWrite_out, branch_out, resultSrc_out, updateCount_out,
               out_valid
    );

    modport slave (
        input  in_valid, op01_in, op11_in, op21_in, op31_in,
               op02_in, op12_in, op22_in, op32_in, op1, op2, rd_in, aluControl_in,
               regWrite_in, memWrite_in, branch_in, resultSrc_in, updateCount_in,
        output stop, res0, res1, res2, res3, sres, zero, rd_out,
               regWrite_out, memWrite_out, branch_out, resultSrc_out, updateCount_out,
               out_valid
    );
endinterface

// File: rtl/exe_vector_unit.sv
// Execute stage: 4-lane vector ALU plus scalar ALU, with bit-serial rotate
// and shift-add multiply that hold the ID/EXE register through stop.
//
// state | meaning
// IDLE  | accept an instruction; single-cycle ops complete here
// ROT   | rotate all lanes one bit per clock until the count expires
// MUL   | shift-add one multiplier bit per clock, WIDTH clocks
// DONE  | result presented for one cycle; ID/EXE still shows the old op
module exe_vector_unit #(
    parameter int WIDTH = 16,
    parameter int ROT_W = 4
) (
    input logic              clk,
    input logic              reset,
    exe_vector_unit_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ROT  = 2'd1;
    localparam logic [1:0] S_MUL  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_XOR  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_ROTL = 4'b0101;
    localparam logic [3:0] OP_ROTR = 4'b0110;
    localparam logic [3:0] OP_MUL  = 4'b0111;
    localparam logic [3:0] OP_SADD = 4'b1000;
    localparam logic [3:0] OP_SSUB = 4'b1001;

    logic [1:0]       state;
    logic [CNT_W-1:0] count;
    logic             dir_left;
    logic [4:0]       ctrl_q, ctrl_out, ctrl_in;
    logic [3:0]       rd_q, rd_reg;
    logic             valid_reg;
    logic [WIDTH-1:0] sres_reg;
    logic             zero_reg;

    logic [WIDTH-1:0] a [4];
    logic [WIDTH-1:0] b [4];
    logic [WIDTH-1:0] alu_res [4];
    logic [WIDTH-1:0] alu_sres;
    logic [WIDTH-1:0] wa [4];
    logic [WIDTH-1:0] wb [4];
    logic [WIDTH-1:0] acc [4];
    logic [WIDTH-1:0] rot_next [4];
    logic [WIDTH-1:0] acc_next [4];
    logic [WIDTH-1:0] res_reg [4];

    logic [ROT_W-1:0] rot_amt;
    logic             is_rot, is_mul, accept_multi, last_step;

    assign a[0] = bus.op01_in;
    assign a[1] = bus.op11_in;
    assign a[2] = bus.op21_in;
    assign a[3] = bus.op31_in;
    assign b[0] = bus.op02_in;
    assign b[1] = bus.op12_in;
    assign b[2] = bus.op22_in;
    assign b[3] = bus.op32_in;

    assign ctrl_in = {bus.regWrite_in, bus.memWrite_in, bus.branch_in,
                      bus.resultSrc_in, bus.updateCount_in};

    assign rot_amt      = bus.op2[ROT_W-1:0];
    assign is_rot       = (bus.aluControl_in == OP_ROTL) || (bus.aluControl_in == OP_ROTR);
    assign is_mul       = (bus.aluControl_in == OP_MUL);
    assign accept_multi = (state == S_IDLE) && bus.in_valid
                          && (is_mul || (is_rot && (rot_amt != '0)));
    assign last_step    = (count == CNT_W'(1));

    // Hold ID/EXE while a multi-cycle op is running; reset overrides.
    assign bus.stop = !reset && ((state == S_ROT) || (state == S_MUL) || accept_multi);

    // A zero-amount rotate falls through to the default (lanes = A).
    always_comb begin
        alu_sres = '0;
        for (int i = 0; i < 4; i++) begin
            alu_res[i] = a[i];
            case (bus.aluControl_in)
                OP_ADD:           alu_res[i] = a[i] + b[i];
                OP_SUB:           alu_res[i] = a[i] - b[i];
                OP_XOR:           alu_res[i] = a[i] ^ b[i];
                OP_AND:           alu_res[i] = a[i] & b[i];
                OP_OR:            alu_res[i] = a[i] | b[i];
                OP_SADD, OP_SSUB: alu_res[i] = '0;
                default:          alu_res[i] = a[i];
            endcase
        end
        case (bus.aluControl_in)
            OP_SADD: alu_sres = bus.op1 + bus.op2;
            OP_SSUB: alu_sres = bus.op1 - bus.op2;
            default: alu_sres = '0;
        endcase
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            rot_next[i] = dir_left ? {wa[i][WIDTH-2:0], wa[i][WIDTH-1]}
                                   : {wa[i][0], wa[i][WIDTH-1:1]};
            acc_next[i] = acc[i] + (wb[i][0] ? wa[i] : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            count     <= '0;
            dir_left  <= 1'b0;
            ctrl_q    <= '0;
            ctrl_out  <= '0;
            rd_q      <= '0;
            rd_reg    <= '0;
            valid_reg <= 1'b0;
            sres_reg  <= '0;
            zero_reg  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                wa[i]      <= '0;
                wb[i]      <= '0;
                acc[i]     <= '0;
                res_reg[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept_multi) begin
                        for (int i = 0; i < 4; i++) begin
                            wa[i]  <= a[i];
                            wb[i]  <= b[i];
                            acc[i] <= '0;
                        end
                        dir_left  <= (bus.aluControl_in == OP_ROTL);
                        count     <= is_mul ? CNT_W'(WIDTH) : CNT_W'(rot_amt);
                        ctrl_q    <= ctrl_in;
                        rd_q      <= bus.rd_in;
                        ctrl_out  <= '0;
                        rd_reg    <= '0;
                        valid_reg <= 1'b0;
                        state     <= is_mul ? S_MUL : S_ROT;
                    end else if (bus.in_valid) begin
                        for (int i = 0; i < 4; i++) res_reg[i] <= alu_res[i];
                        sres_reg  <= alu_sres;
                        zero_reg  <= (alu_sres == '0);
                        ctrl_out  <= ctrl_in;
                        rd_reg    <= bus.rd_in;
                        valid_reg <= 1'b1;
                    end else begin
                        ctrl_out  <= '0;
                        rd_reg    <= '0;
                        valid_reg <= 1'b0;
                    end
                end
                S_ROT, S_MUL: begin
                    count <= count - CNT_W'(1);
                    for (int i = 0; i < 4; i++) begin
                        if (state == S_ROT) begin
                            wa[i] <= rot_next[i];
                        end else begin
                            acc[i] <= acc_next[i];
                            wa[i]  <= wa[i] << 1;
                            wb[i]  <= wb[i] >> 1;
                        end
                    end
                    if (last_step) begin
                        for (int i = 0; i < 4; i++)
                            res_reg[i] <= (state == S_ROT) ? rot_next[i] : acc_next[i];
                        sres_reg  <= '0;
                        zero_reg  <= 1'b1;
                        ctrl_out  <= ctrl_q;
                        rd_reg    <= rd_q;
                        valid_reg <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                default: begin
                    ctrl_out  <= '0;
                    rd_reg    <= '0;
                    valid_reg <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.res0            = res_reg[0];
    assign bus.res1            = res_reg[1];
    assign bus.res2            = res_reg[2];
    assign bus.res3            = res_reg[3];
    assign bus.sres            = sres_reg;
    assign bus.zero            = zero_reg;
    assign bus.rd_out          = rd_reg;
    assign bus.out_valid       = valid_reg;
    assign bus.regWrite_out    = ctrl_out[4];
    assign bus.memWrite_out    = ctrl_out[3];
    assign bus.branch_out      = ctrl_out[2];
    assign bus.resultSrc_out   = ctrl_out[1];
    assign bus.updateCount_out = ctrl_out[0];
endmodule
